// File: rtl/gpr_multi_if.sv
// Bus bundle for gpr_multi: read ports, write-back port, issue port and scoreboard status.
interface gpr_multi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] read_addr;
  logic [NUM_RD*DATA_W-1:0] read_data;
  logic [NUM_RD-1:0]        read_busy;
  logic [ADDR_W-1:0]        write;
  logic [DATA_W-1:0]        write_data;
  logic                     wd;
  logic [DATA_W/8-1:0]      wbe;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_addr;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output read_addr, write, write_data, wd, wbe, issue_valid, issue_addr,
    input  read_data, read_busy, busy_cnt
  );

  modport slave (
    input  read_addr, write, write_data, wd, wbe, issue_valid, issue_addr,
    output read_data, read_busy, busy_cnt
  );
endinterface

// File: rtl/gpr_multi.sv
// Multi-read-port register file with byte-enabled writes and a pending-write scoreboard.
// Optional write-through forwarding to the read ports when GPR_BYPASS_EN is defined.
module gpr_multi #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input logic        clk,
  input logic        rst_n,
  gpr_multi_if.slave bus
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int NBYTES = DATA_W/8;

  logic [DATA_W-1:0] rgs_q [DEPTH];
  logic [DATA_W-1:0] rgs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0] merged;
  logic              wr_en, set_en, inc, dec;

  always_comb begin
    merged = rgs_q[bus.write];
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (bus.wbe[i]) merged[i*8 +: 8] = bus.write_data[i*8 +: 8];
    end

    wr_en  = bus.wd && (bus.write != '0);
    set_en = bus.issue_valid && (bus.issue_addr != '0);

    // Count only real transitions; a same-address set/clear leaves the bit set.
    inc = set_en && !busy_q[bus.issue_addr];
    dec = wr_en && busy_q[bus.write] && !(set_en && (bus.issue_addr == bus.write));
    cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};

    rgs_d = rgs_q;
    if (wr_en) rgs_d[bus.write] = merged;

    busy_d = busy_q;
    if (wr_en)  busy_d[bus.write]      = 1'b0;
    if (set_en) busy_d[bus.issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgs_q  <= '{default: '0};
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      rgs_q  <= rgs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra = bus.read_addr[k*ADDR_W +: ADDR_W];
`ifdef GPR_BYPASS_EN
    assign hit = wr_en && (ra == bus.write);
`else
    assign hit = 1'b0;
`endif
    assign bus.read_data[k*DATA_W +: DATA_W] =
      hit ? merged : ((ra == '0) ? '0 : rgs_q[ra]);
    assign bus.read_busy[k] =
      hit ? (set_en && (bus.issue_addr == bus.write)) : busy_q[ra];
  end

  assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_gpr_multi.sv
// Self-checking bench for gpr_multi: directed table, corner sequences, randomized model check.
module tb_gpr_multi;
`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gpr_multi_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifc ();

  gpr_multi #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic        wd;
    logic [4:0]  w;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t tbl [11];

  // reference model state
  logic [31:0] mem [32];
  bit          bsy [32];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic wd, input logic [4:0] w, input logic [31:0] wdata,
                        input logic [3:0] wbe, input logic iv, input logic [4:0] ia,
                        input logic [4:0] ra0, input logic [4:0] ra1);
    ifc.wd          = wd;
    ifc.write       = w;
    ifc.write_data  = wdata;
    ifc.wbe         = wbe;
    ifc.issue_valid = iv;
    ifc.issue_addr  = ia;
    ifc.read_addr   = {ra1, ra0};
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'd0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      bsy[i] = 1'b0;
    end
  endtask

  // pulse reset inside the low clock phase, away from any posedge
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_clear();
  endtask

  function automatic logic [31:0] rd(input int k);
    return ifc.read_data[k*32 +: 32];
  endfunction

  initial begin
    logic [31:0] m, e;
    logic        eb;
    int          cnt;
    logic [4:0]  ra [2];

    tbl[0]  = '{1'b1, 5'd5,  32'h11223344, 4'hF,    1'b0, 5'd0,  5'd1,  5'd2,  32'h0,        32'h0,        2'b00, 6'd0};
    tbl[1]  = '{1'b1, 5'd6,  32'h000000FF, 4'hF,    1'b0, 5'd0,  5'd5,  5'd0,  32'h11223344, 32'h0,        2'b00, 6'd0};
    tbl[2]  = '{1'b1, 5'd5,  32'hAABBCCDD, 4'b0101, 1'b0, 5'd0,  5'd6,  5'd0,  32'h000000FF, 32'h0,        2'b00, 6'd0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        4'h0,    1'b1, 5'd7,  5'd5,  5'd7,  32'h11BB33DD, 32'h0,        2'b00, 6'd0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        4'h0,    1'b1, 5'd9,  5'd7,  5'd9,  32'h0,        32'h0,        2'b01, 6'd1};
    tbl[5]  = '{1'b1, 5'd7,  32'h00000077, 4'hF,    1'b1, 5'd10, 5'd9,  5'd10, 32'h0,        32'h0,        2'b01, 6'd2};
    tbl[6]  = '{1'b1, 5'd9,  32'h00000099, 4'hF,    1'b1, 5'd9,  5'd7,  5'd10, 32'h00000077, 32'h0,        2'b10, 6'd2};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        4'h0,    1'b0, 5'd0,  5'd9,  5'd9,  32'h00000099, 32'h00000099, 2'b11, 6'd2};
    tbl[8]  = '{1'b1, 5'd0,  32'hDEADBEEF, 4'hF,    1'b1, 5'd0,  5'd0,  5'd10, 32'h0,        32'h0,        2'b10, 6'd2};
    tbl[9]  = '{1'b1, 5'd10, 32'hFFFFFFFF, 4'h0,    1'b0, 5'd0,  5'd0,  5'd9,  32'h0,        32'h00000099, 2'b10, 6'd2};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        4'h0,    1'b0, 5'd0,  5'd10, 5'd7,  32'h0,        32'h00000077, 2'b00, 6'd1};

    // reset held with an active write to r3
    set_in(1'b1, 5'd3, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd3, 5'd3, 5'd0);
    tick();
    tick();
    chk("rst_rd0", rd(0), 32'h0);
    chk("rst_rd1", rd(1), 32'h0);
    chk("rst_busy", ifc.read_busy, 2'b00);
    chk("rst_cnt", ifc.busy_cnt, 6'd0);
    set_in(1'b0, 5'd3, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0, 5'd3, 5'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_r3_after", rd(0), 32'h0);

    // full-word writes r1..r31 and ignored write to r0
    for (int n = 1; n < 32; n++) begin
      set_in(1'b1, 5'(n), 32'(n), 4'hF, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
    end
    set_in(1'b1, 5'd0, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    idle();
    for (int n = 0; n < 32; n++) begin
      ifc.read_addr = {5'((n + 1) % 32), 5'(n)};
      #1;
      chk("full_rd0", rd(0), 32'(n));
      chk("full_rd1", rd(1), 32'((n + 1) % 32));
    end

    // directed table from a clean state
    do_reset();
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].wd, tbl[i].w, tbl[i].wdata, tbl[i].wbe, tbl[i].iv, tbl[i].ia,
             tbl[i].ra0, tbl[i].ra1);
      #1;
      chk($sformatf("tbl%0d_rd0", i), rd(0), tbl[i].e0);
      chk($sformatf("tbl%0d_rd1", i), rd(1), tbl[i].e1);
      chk($sformatf("tbl%0d_busy", i), ifc.read_busy, tbl[i].eb);
      chk($sformatf("tbl%0d_cnt", i), ifc.busy_cnt, tbl[i].ecnt);
      tick();
    end

    // same-cycle write/read forwarding
    set_in(1'b1, 5'd4, 32'h0, 4'hF, 1'b0, 5'd0, 5'd0, 5'd4);
    tick();
    set_in(1'b1, 5'd4, 32'h5A5A5A5A, 4'hF, 1'b0, 5'd0, 5'd0, 5'd4);
    #1;
    chk("byp_rd1", rd(1), BYP ? 32'h5A5A5A5A : 32'h0);
    chk("byp_busy1", ifc.read_busy[1], 1'b0);
    tick();
    idle();
    ifc.read_addr = {5'd4, 5'd0};
    #1;
    chk("byp_next_rd1", rd(1), 32'h5A5A5A5A);
    set_in(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd4, 5'd0, 5'd4);
    tick();
    set_in(1'b1, 5'd4, 32'h1, 4'h1, 1'b1, 5'd4, 5'd0, 5'd4);
    #1;
    chk("byp_iss_busy1", ifc.read_busy[1], 1'b1);
    tick();
    set_in(1'b1, 5'd4, 32'h2, 4'h1, 1'b0, 5'd0, 5'd0, 5'd4);
    #1;
    chk("byp_wr_busy1", ifc.read_busy[1], BYP ? 1'b0 : 1'b1);
    chk("byp_wr_rd1", rd(1), BYP ? 32'h5A5A5A02 : 32'h5A5A5A01);
    tick();
    idle();
    ifc.read_addr = {5'd4, 5'd0};
    #1;
    chk("byp_after_busy1", ifc.read_busy[1], 1'b0);

    // asynchronous reset between edges
    do_reset();
    set_in(1'b1, 5'd5, 32'h12345678, 4'hF, 1'b1, 5'd11, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd12, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd13, 5'd0, 5'd0);
    tick();
    idle();
    ifc.read_addr = {5'd11, 5'd5};
    #1;
    chk("ar_cnt_pre", ifc.busy_cnt, 6'd3);
    chk("ar_rd0_pre", rd(0), 32'h12345678);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_cnt", ifc.busy_cnt, 6'd0);
    chk("ar_rd0", rd(0), 32'h0);
    chk("ar_busy", ifc.read_busy, 2'b00);
    rst_n = 1'b1;
    model_clear();

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic       r_wd, r_iv;
      logic [4:0] r_w, r_ia;
      logic [31:0] r_data;
      logic [3:0] r_wbe;
      r_wd   = 1'($urandom_range(0, 1));
      r_iv   = 1'($urandom_range(0, 1));
      r_w    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      r_ia   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      r_data = $urandom;
      r_wbe  = 4'($urandom_range(0, 15));
      ra[0]  = ($urandom_range(0, 3) == 0) ? r_w : 5'($urandom_range(0, 7));
      ra[1]  = ($urandom_range(0, 3) == 0) ? r_w : 5'($urandom_range(0, 31));
      set_in(r_wd, r_w, r_data, r_wbe, r_iv, r_ia, ra[0], ra[1]);

      m = mem[r_w];
      for (int b = 0; b < 4; b++) if (r_wbe[b]) m[b*8 +: 8] = r_data[b*8 +: 8];
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += int'(bsy[i]);
      #1;
      for (int k = 0; k < 2; k++) begin
        e  = (ra[k] == 5'd0) ? 32'h0 : mem[ra[k]];
        eb = bsy[ra[k]];
        if (BYP && r_wd && r_w != 5'd0 && ra[k] == r_w) begin
          e  = m;
          eb = r_iv && (r_ia == r_w);
        end
        chk($sformatf("rnd%0d_rd%0d", c, k), rd(k), e);
        chk($sformatf("rnd%0d_busy%0d", c, k), ifc.read_busy[k], eb);
      end
      chk($sformatf("rnd%0d_cnt", c), ifc.busy_cnt, 6'(cnt));
      tick();
      if (r_wd && r_w != 5'd0) begin
        mem[r_w] = m;
        bsy[r_w] = 1'b0;
      end
      if (r_iv && r_ia != 5'd0) bsy[r_ia] = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpr_multi.md
Name: gpr_multi

Overview:
- Parametrised general-purpose register file; the next generation of the CPU datapath `gpr`.
- Adds a configurable data width and depth, NUM_RD read ports, byte-enabled writes and a per-register pending-write scoreboard.
- Sits between decode (issue marks a destination busy) and write-back (the write clears busy).
- Register 0 is hard-wired to zero.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- read_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- read_data  out  NUM_RD*DATA_W  packed read data, port k = [k*DATA_W +: DATA_W].
- read_busy  out  NUM_RD  1 = register addressed by port k has a pending write.
- write  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- wd  in  1  write enable.
- wbe  in  DATA_W/8  byte enables for the write; bit i covers bits [8i+7:8i].
- issue_valid  in  1  mark issue_addr as pending.
- issue_addr  in  ADDR_W  destination register being issued.
- busy_cnt  out  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Reset (rst_n low, async): all registers = 0, all busy bits = 0, busy_cnt = 0. Consequently read_data = 0 and read_busy = 0 while reset is held.
- Reads are combinational, with zero latency.
  - read_data[k] = rgs[read_addr[k]].
  - Address 0 always returns 0.
- Write at posedge clk when wd=1 and write != 0:
  - each byte i with wbe[i]=1 takes write_data byte i;
  - other bytes are unchanged.
- wd=1 with wbe=0: no data change, but busy is still cleared (write-back of a cancelled op).
- Writes to address 0 are ignored; they have no data effect and no busy effect.
- Scoreboard, at posedge:
  - busy[write] is cleared if wd=1;
  - busy[issue_addr] is set if issue_valid=1 and issue_addr != 0.
- Same address issued and written in one cycle: set wins, busy stays 1 (new producer supersedes the old one). Data is still written.
- Issue to an already-busy register: busy stays 1 and busy_cnt is unchanged.
- Write to a non-busy register: busy stays 0 and busy_cnt is unchanged.
- busy_cnt is maintained incrementally each cycle:
  - +1 if a 0->1 transition occurs;
  - -1 if a 1->0 transition occurs;
  - net 0 if both occur on different addresses.
- busy_cnt never exceeds 2**ADDR_W-1; r0 is never busy.
- read_busy[k] = busy[read_addr[k]], except as modified by GPR_BYPASS_EN below.
- Reset asserted mid-cycle clears everything immediately. The first posedge after release behaves as a normal cycle.

Optional Feature:
- Macro: GPR_BYPASS_EN.
- Defined (write-through forwarding): when wd=1, write != 0 and read_addr[k] == write in the same cycle:
  - read_data[k] = merged value (new bytes where wbe=1, stored bytes elsewhere);
  - read_busy[k] = 0, unless issue_valid=1 and issue_addr == write in that same cycle.
- Undefined: reads return the pre-write stored value and stored busy in that cycle; the new value is visible from the next cycle.

Test Plan:
- Reset: hold rst_n=0 with wd=1 and write=3 -> all read_data=0, read_busy=0, busy_cnt=0; after release r3 still reads 0.
- Full-word writes: write r1..r31 with value = index, wbe=4'hF -> read port 0 at addr n and port 1 at addr (n+1)%32 return n and (n+1)%32; r0 reads 0 after a write of 32'hDEADBEEF to address 0.
- Byte enables: r5=32'h11223344, then write 32'hAABBCCDD with wbe=4'b0101 -> r5 reads 32'h11BB33DD.
- Scoreboard: issue r7, then r9 -> busy_cnt=2 and read_busy set for both. Same cycle: write r7 while issuing r10 -> busy_cnt stays 2, r7 not busy. Same cycle: issue r9 while writing r9 -> r9 stays busy, busy_cnt=2.
- Bypass: r4=0, same cycle write r4=32'h5A5A5A5A while reading r4 on port 1 -> port 1 reads 32'h5A5A5A5A with GPR_BYPASS_EN defined, 0 without; both builds read 32'h5A5A5A5A next cycle.
- Async reset mid-run: with busy_cnt=3, drop rst_n between edges -> busy_cnt and all read_data go to 0 without waiting for a clock edge.
